// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle ARM-subset datapath sharing one memory port for fetch and data
module multicycle_datapath #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          COND_EN      = 1,
    parameter logic [31:0] REG_INIT     = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic [31:0] PC_out,
    output logic [2:0]  State,
    output logic        Retire,
    output logic [3:0]  ALUFlags
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_ALUWB  = 3'd3,
        S_MEM    = 3'd4,
        S_LDWB   = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regs [15];
    logic [3:0]  flags;            // {N, Z, C, V}
    logic        retire;
    logic [31:0] op_a;             // Rn value captured in DECODE
    logic [31:0] op_b;             // Src2 captured in DECODE
    logic [31:0] rd_val;           // Rd value captured in DECODE (store data)
    logic [31:0] alu_result;
    logic [31:0] data_addr;
    logic [31:0] ld_data;
    logic        mem_we;

    // instruction fields
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm_sel;
    logic [3:0]  cmd;
    logic        bit20;            // S for data-processing, L for memory
    logic        up;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [7:0]  imm8;
    logic [11:0] imm12;
    logic [23:0] imm24;

    assign cond    = ir[31:28];
    assign op      = ir[27:26];
    assign imm_sel = ir[25];
    assign cmd     = ir[24:21];
    assign bit20   = ir[20];
    assign up      = ir[23];
    assign rn      = ir[19:16];
    assign rd      = ir[15:12];
    assign rm      = ir[3:0];
    assign imm8    = ir[7:0];
    assign imm12   = ir[11:0];
    assign imm24   = ir[23:0];

    logic [31:0] rn_read;
    logic [31:0] rm_read;
    logic [31:0] rd_read;
    logic        cond_true;
    logic        cond_pass;
    logic [32:0] sum_add;
    logic [32:0] sum_sub;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        alu_ok;
    logic [3:0]  alu_flags;
    logic [31:0] mem_ea;
    logic [31:0] br_target;

    // Register-file reads; R15 returns the address of the instruction plus 8 (PC already advanced by 4)
    always_comb begin
        rn_read = (rn == 4'd15) ? pc + 32'd4 : regs[rn];
        rm_read = (rm == 4'd15) ? pc + 32'd4 : regs[rm];
        rd_read = (rd == 4'd15) ? pc + 32'd4 : regs[rd];
    end

    // Condition evaluation against the architectural NZCV register
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = flags[2];
            4'b0001: cond_true = !flags[2];
            4'b0010: cond_true = flags[1];
            4'b0011: cond_true = !flags[1];
            4'b0100: cond_true = flags[3];
            4'b0101: cond_true = !flags[3];
            4'b0110: cond_true = flags[0];
            4'b0111: cond_true = !flags[0];
            4'b1000: cond_true = flags[1] && !flags[2];
            4'b1001: cond_true = !flags[1] || flags[2];
            4'b1010: cond_true = (flags[3] == flags[0]);
            4'b1011: cond_true = (flags[3] != flags[0]);
            4'b1100: cond_true = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_true = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
        cond_pass = (COND_EN == 0) ? 1'b1 : cond_true;
    end

    // ALU on the operands captured in DECODE; SUB carry is the inverted borrow
    always_comb begin
        sum_add = {1'b0, op_a} + {1'b0, op_b};
        sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;
        alu_res = 32'h0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ok  = 1'b1;
        case (cmd)
            4'b0000: alu_res = op_a & op_b;
            4'b0010: begin
                alu_res = sum_sub[31:0];
                alu_c   = sum_sub[32];
                alu_v   = (op_a[31] != op_b[31]) && (sum_sub[31] != op_a[31]);
            end
            4'b0100: begin
                alu_res = sum_add[31:0];
                alu_c   = sum_add[32];
                alu_v   = (op_a[31] == op_b[31]) && (sum_add[31] != op_a[31]);
            end
            4'b1100: alu_res = op_a | op_b;
            default: alu_ok = 1'b0;
        endcase
        alu_flags = {alu_res[31], (alu_res == 32'h0), alu_c, alu_v};
    end

    // Effective address for loads/stores and branch target
    always_comb begin
        mem_ea    = up ? op_a + {20'h0, imm12} : op_a - {20'h0, imm12};
        br_target = pc + 32'd4 + {{6{imm24[23]}}, imm24, 2'b00};
    end

    // Main control FSM with architectural state updates
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_FETCH;
            pc         <= RESET_VECTOR;
            ir         <= 32'h0;
            flags      <= 4'h0;
            retire     <= 1'b0;
            op_a       <= 32'h0;
            op_b       <= 32'h0;
            rd_val     <= 32'h0;
            alu_result <= 32'h0;
            data_addr  <= 32'h0;
            ld_data    <= 32'h0;
            mem_we     <= 1'b0;
            for (int i = 0; i < 15; i++) begin
                regs[i] <= REG_INIT;
            end
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (MemReady) begin
                        ir    <= MemRData;
                        pc    <= pc + 32'd4;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a   <= rn_read;
                    op_b   <= imm_sel ? {24'h0, imm8} : rm_read;
                    rd_val <= rd_read;
                    if (!cond_pass) begin
                        retire <= 1'b1;
                        state  <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        2'b00: begin
                            if (alu_ok) begin
                                alu_result <= alu_res;
                                if (bit20) begin
                                    flags <= alu_flags;
                                end
                                state <= S_ALUWB;
                            end else begin
                                retire <= 1'b1;
                                state  <= S_FETCH;
                            end
                        end
                        2'b01: begin
                            data_addr <= mem_ea & 32'hFFFF_FFFC;
                            mem_we    <= !bit20;
                            state     <= S_MEM;
                        end
                        2'b10: begin
                            pc     <= br_target;
                            retire <= 1'b1;
                            state  <= S_FETCH;
                        end
                        default: begin
                            retire <= 1'b1;
                            state  <= S_FETCH;
                        end
                    endcase
                end
                S_ALUWB: begin
                    if (rd == 4'd15) begin
                        pc <= alu_result;
                    end else begin
                        regs[rd] <= alu_result;
                    end
                    retire <= 1'b1;
                    state  <= S_FETCH;
                end
                S_MEM: begin
                    if (MemReady) begin
                        if (mem_we) begin
                            retire <= 1'b1;
                            state  <= S_FETCH;
                        end else begin
                            ld_data <= MemRData;
                            state   <= S_LDWB;
                        end
                    end
                end
                S_LDWB: begin
                    if (rd == 4'd15) begin
                        pc <= ld_data;
                    end else begin
                        regs[rd] <= ld_data;
                    end
                    retire <= 1'b1;
                    state  <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Memory request is a decode of the state, forced low while reset is held
    assign MemReq   = RST_N && ((state == S_FETCH) || (state == S_MEM));
    assign MemWE    = (state == S_MEM) && mem_we;
    assign MemAddr  = (state == S_MEM) ? data_addr : (pc & 32'hFFFF_FFFC);
    assign MemWData = rd_val;
    assign PC_out   = pc;
    assign State    = state;
    assign Retire   = retire;
    assign ALUFlags = flags;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - randomized program bench checked against an instruction-level model
module tb_multicycle_datapath;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] RINIT = 32'h0000_0000;

    logic        CLK;
    logic        RST_N;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemReady;
    logic [31:0] MemRData;
    logic [31:0] PC_out;
    logic [2:0]  State;
    logic        Retire;
    logic [3:0]  ALUFlags;

    multicycle_datapath #(
        .RESET_VECTOR (RV),
        .COND_EN      (1),
        .REG_INIT     (RINIT)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .MemReq   (MemReq),
        .MemWE    (MemWE),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemReady (MemReady),
        .MemRData (MemRData),
        .PC_out   (PC_out),
        .State    (State),
        .Retire   (Retire),
        .ALUFlags (ALUFlags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] r       [16];
    logic [31:0] m_pc;
    bit          fn, fz, fc, fv;
    int          n_cmp = 0;
    int          n_err = 0;
    int          ready_mode = 0;
    int          hold = 0;
    bit          wr_seen;
    logic [31:0] wr_addr, wr_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_dp(input logic [3:0] c, input bit i, input logic [3:0] cmd,
                                           input bit s, input logic [3:0] rn, input logic [3:0] rd,
                                           input logic [11:0] op2);
        return {c, 2'b00, i, cmd, s, rn, rd, op2};
    endfunction

    function automatic logic [31:0] enc_mem(input logic [3:0] c, input bit u, input bit b, input bit w,
                                            input bit l, input logic [3:0] rn, input logic [3:0] rd,
                                            input logic [11:0] imm);
        return {c, 2'b01, 1'b0, 1'b1, u, b, w, l, rn, rd, imm};
    endfunction

    function automatic logic [31:0] enc_br(input logic [3:0] c, input bit l, input logic [23:0] imm);
        return {c, 3'b101, l, imm};
    endfunction

    function automatic logic [31:0] gen_random(input int word);
        logic [3:0] c, rd, cm;
        int kind;
        bit l, u;
        c    = $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15));
        kind = $urandom_range(0, 9);
        if (kind == 8 && word > 95) kind = 0;
        if (kind <= 5) begin
            case ($urandom_range(0, 4))
                0: cm = 4'b0000;
                1: cm = 4'b0010;
                2: cm = 4'b0100;
                3: cm = 4'b1100;
                default: cm = 4'($urandom_range(0, 15));
            endcase
            return enc_dp(c, 1'($urandom_range(0, 1)), cm, 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(1, 12)), 12'($urandom));
        end else if (kind <= 7) begin
            l  = 1'($urandom_range(0, 1));
            u  = ($urandom_range(0, 3) != 0);
            rd = l ? 4'($urandom_range(1, 12)) : 4'($urandom_range(0, 15));
            return enc_mem(c, u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l, 4'd13, rd,
                           u ? 12'(4 * $urandom_range(0, 63)) : 12'(4 * $urandom_range(1, 13)));
        end else if (kind == 8) begin
            return enc_br(c, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 2)));
        end
        return {c, 2'b11, 26'($urandom)};
    endfunction

    function automatic bit cond_holds(input logic [3:0] c);
        case (c)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return fn == fv;
            4'd11: return fn != fv;
            4'd12: return !fz && (fn == fv);
            4'd13: return fz || (fn != fv);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) r[i] = RINIT;
        m_pc = RV;
        {fn, fz, fc, fv} = 4'h0;
    endtask

    // Executes one instruction architecturally; base is the zero-wait cycle count
    task automatic model_step(output int base, output bit is_st, output logic [31:0] st_a,
                              output logic [31:0] st_d);
        logic [31:0] w, ia, a, b, res, ea;
        logic [3:0]  rn, rd, rm;
        longint      wide, sw;
        bit          c_new, v_new;
        ia = m_pc;
        w  = ref_mem[ia[9:2]];
        m_pc = ia + 32'd4;
        is_st = 1'b0; st_a = 32'h0; st_d = 32'h0; res = 32'h0;
        rn = w[19:16]; rd = w[15:12]; rm = w[3:0];
        a = (rn == 4'd15) ? ia + 32'd8 : r[rn];
        if (!cond_holds(w[31:28])) begin
            base = 2;
        end else if (w[27:26] == 2'b00) begin
            b = w[25] ? {24'h0, w[7:0]} : ((rm == 4'd15) ? ia + 32'd8 : r[rm]);
            base = 4; c_new = 1'b0; v_new = 1'b0;
            case (w[24:21])
                4'b0000: res = a & b;
                4'b1100: res = a | b;
                4'b0100: begin
                    wide  = longint'({32'h0, a}) + longint'({32'h0, b});
                    res   = wide[31:0];
                    c_new = wide[32];
                    sw    = longint'($signed(a)) + longint'($signed(b));
                    v_new = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
                end
                4'b0010: begin
                    res   = a - b;
                    c_new = (a >= b);
                    sw    = longint'($signed(a)) - longint'($signed(b));
                    v_new = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
                end
                default: base = 3;
            endcase
            if (base == 4) begin
                if (w[20]) {fn, fz, fc, fv} = {res[31], (res == 32'h0), c_new, v_new};
                if (rd == 4'd15) m_pc = res;
                else r[rd] = res;
            end
        end else if (w[27:26] == 2'b01) begin
            ea = w[23] ? a + {20'h0, w[11:0]} : a - {20'h0, w[11:0]};
            if (w[20]) begin
                base = 5;
                if (rd == 4'd15) m_pc = ref_mem[ea[9:2]];
                else r[rd] = ref_mem[ea[9:2]];
            end else begin
                base  = 4;
                st_d  = (rd == 4'd15) ? ia + 32'd8 : r[rd];
                ref_mem[ea[9:2]] = st_d;
                is_st = 1'b1;
                st_a  = ea;
            end
        end else if (w[27:26] == 2'b10) begin
            m_pc = ia + 32'd8 + {{6{w[23]}}, w[23:0], 2'b00};
            base = 3;
        end else begin
            base = 3;
        end
    endtask

    // Serves memory and waits for the Retire pulse of one instruction
    task automatic run_one(output int cyc, output int waits, output bit ok);
        bit rdy;
        cyc = 0; waits = 0; ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = (hold >= 2);
            endcase
            MemReady = rdy;
            MemRData = mem[MemAddr[9:2]];
            if (MemReq && !rdy) begin
                waits++;
                hold++;
            end
            if (MemReq && rdy) begin
                hold = 0;
                if (MemWE) begin
                    mem[MemAddr[9:2]] = MemWData;
                    wr_seen = 1'b1;
                    wr_addr = MemAddr;
                    wr_data = MemWData;
                end
            end
            @(posedge CLK);
            #1;
            cyc++;
            if (Retire) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int cyc, waits, base, steps;
        bit ok, is_st;
        logic [31:0] st_a, st_d, ia;

        RST_N = 1'b0;
        MemReady = 1'b0;
        MemRData = 32'h0;

        for (int i = 0; i < 256; i++) mem[i] = (i >= 115) ? $urandom : 32'h0;
        mem[0]  = enc_dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd1, 12'd5);     // ADD R1,R0,#5
        mem[1]  = enc_dp(4'hE, 1'b0, 4'b0010, 1'b1, 4'd1, 4'd2, 12'd1);     // SUBS R2,R1,R1
        mem[2]  = enc_br(4'h0, 1'b0, 24'd2);                                // BEQ +16
        mem[3]  = enc_dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd5, 12'hFF);
        mem[4]  = mem[3];
        mem[5]  = mem[3];
        mem[6]  = enc_dp(4'h1, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd4, 12'd7);     // ADDNE R4,R0,#7
        mem[7]  = enc_dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd13, 12'd128);
        mem[8]  = enc_dp(4'hE, 1'b0, 4'b0100, 1'b0, 4'd13, 4'd13, 12'd13);
        mem[9]  = mem[8];
        mem[10] = enc_mem(4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 4'd1, 12'd16); // STR R1,[R13,#16]
        mem[11] = enc_mem(4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 4'd3, 12'd16); // LDR R3,[R13,#16]
        mem[12] = enc_dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd15, 4'd6, 12'd0);    // ADD R6,R15,#0
        mem[13] = enc_dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd15, 4'd15, 12'd0);   // ADD PC,R15,#0
        mem[14] = mem[3];
        for (int i = 15; i < 100; i++) mem[i] = gen_random(i);
        for (int i = 0; i < 15; i++)
            mem[100 + i] = enc_mem(4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 4'(i), 12'(256 + 4 * i));
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        model_reset();

        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_pc", PC_out, RV);
        check_eq("rst_state", 32'(State), 32'd0);
        check_eq("rst_flags", 32'(ALUFlags), 32'd0);
        check_eq("rst_retire", 32'(Retire), 32'd0);
        check_eq("rst_memreq", 32'(MemReq), 32'd0);
        #1 RST_N = 1'b1;
        #1;
        check_eq("first_fetch_req", 32'(MemReq), 32'd1);
        check_eq("first_fetch_addr", MemAddr, RV);

        steps = 0;
        while (m_pc != 32'd460 && steps < 400) begin
            steps++;
            ia = m_pc;
            ready_mode = (ia < 32'd40) ? 0 : ((ia < 32'd48) ? 2 : 1);
            wr_seen = 1'b0;
            run_one(cyc, waits, ok);
            if (!ok) begin
                check_eq("retire_timeout", 32'd0, 32'd1);
                break;
            end
            model_step(base, is_st, st_a, st_d);
            check_eq("latency", 32'(cyc), 32'(base + waits));
            check_eq("pc", PC_out, m_pc);
            check_eq("flags", 32'(ALUFlags), 32'({fn, fz, fc, fv}));
            check_eq("state_after_retire", 32'(State), 32'd0);
            if (is_st) begin
                check_eq("store_seen", 32'(wr_seen), 32'd1);
                check_eq("store_addr", wr_addr, st_a);
                check_eq("store_data", wr_data, st_d);
            end
            if (ia == 32'd0) check_eq("add_imm_latency", 32'(cyc), 32'd4);
            if (ia == 32'd4) check_eq("subs_zc_flags", 32'(ALUFlags), 32'b0110);
            if (ia == 32'd8) check_eq("beq_taken_pc", PC_out, 32'd24);
            if (ia == 32'd24) check_eq("addne_skip_latency", 32'(cyc), 32'd2);
            if (ia == 32'd52) check_eq("add_pc_r15", PC_out, 32'd60);
        end
        check_eq("program_end", m_pc, 32'd460);
        for (int i = 115; i < 256; i++) check_eq("data_mem", mem[i], ref_mem[i]);
        check_eq("r1_via_store", mem[132], 32'd5);

        // reset while a load sits in MEM
        @(posedge CLK);
        #1 RST_N = 1'b0;
        mem[0]   = enc_dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd7, 12'd9);       // ADD R7,R0,#9
        mem[1]   = enc_mem(4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 12'h200); // LDR R7,[R0,#0x200]
        mem[128] = 32'hCAFE_F00D;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        ready_mode = 0;
        run_one(cyc, waits, ok);
        check_eq("abort_pre_retire", 32'(ok), 32'd1);
        check_eq("abort_pre_pc", PC_out, 32'd4);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            MemReady = (State == 3'd0);
            MemRData = mem[MemAddr[9:2]];
            @(posedge CLK);
            #1;
            if (State == 3'd4) break;
        end
        check_eq("ldr_in_mem", 32'(State), 32'd4);
        check_eq("ldr_memreq", 32'(MemReq), 32'd1);
        check_eq("ldr_addr", MemAddr, 32'h200);
        RST_N = 1'b0;
        #1;
        check_eq("abort_memreq", 32'(MemReq), 32'd0);
        check_eq("abort_state", 32'(State), 32'd0);
        check_eq("abort_pc", PC_out, RV);
        mem[0] = enc_mem(4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 12'h204); // STR R7,[R0,#0x204]
        @(posedge CLK);
        #2 RST_N = 1'b1;
        #1;
        check_eq("refetch_req", 32'(MemReq), 32'd1);
        check_eq("refetch_addr", MemAddr, RV);
        wr_seen = 1'b0;
        run_one(cyc, waits, ok);
        check_eq("post_abort_retire", 32'(ok), 32'd1);
        check_eq("post_abort_store_seen", 32'(wr_seen), 32'd1);
        check_eq("post_abort_store_addr", wr_addr, 32'h204);
        check_eq("post_abort_r7", wr_data, RINIT);
        check_eq("post_abort_latency", 32'(cyc), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
